div_sequencer: RTL
==================

# div_sequencer

Multi-cycle sequencer for the RV32M divide/remainder group (DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the EX stage. It accepts a divide operation decoded by the control unit and runs a 32-iteration restoring division. While it runs, it holds the pipeline stalled through BUSY, then presents the result with a one-cycle DONE pulse.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  EX stage holds a valid instruction; sampled only in IDLE.
- ALU_OPCODE  in  5  decoded ALU op: 5'b01100 DIV, 5'b01101 DIVU, 5'b01110 REM, 5'b01111 REMU; all other codes are ignored.
- OPERAND1  in  32  dividend (rs1).
- OPERAND2  in  32  divisor (rs2).
- FLUSH  in  1  kills the in-flight operation (branch/jump redirect).
- BUSY  out  1  stall request to the hazard/stall logic.
- DONE  out  1  one-cycle pulse; RESULT is valid.
- RESULT  out  32  quotient or remainder.

## Operation
- States: IDLE, RUN, SIGN, DONE.
- Accept: in IDLE with START=1, FLUSH=0 and a divide opcode.
  - Latch op_is_rem, op_is_signed, neg_q = signed & (a[31]^b[31]) and neg_r = signed & a[31].
  - Latch the absolute values of the operands (signed ops) or the raw operands (unsigned ops).
  - Clear rem[32:0] and set count=0.
- Fast path, decided at accept:
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend. Go straight to DONE.
  - Signed with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Go straight to DONE.
- RUN, one iteration per cycle:
  - Shift {rem,quo} left by one, bringing in the quotient MSB.
  - If rem ≥ divisor, subtract the divisor and set quo[0]=1.
  - count increments; after the 32nd iteration go to SIGN.
- SIGN:
  - Negate quo (two's complement) if neg_q; negate rem if neg_r.
  - Load RESULT with rem if op_is_rem, otherwise quo. Go to DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE. START in the DONE state is ignored.
- Width rules: rem is 33 bits so the compare/subtract cannot overflow. Negation is 32-bit modulo arithmetic.
- BUSY = (state ∈ {RUN, SIGN}) | (IDLE & START & divide opcode & ~FLUSH). This is combinational, so the pipeline stalls in the accept cycle. BUSY=0 in DONE, so EX advances at the end of the DONE cycle and captures RESULT.
- FLUSH in any non-IDLE state: go to IDLE on the next edge. DONE is not pulsed and RESULT is unchanged. FLUSH together with START in IDLE means no accept.
- A START with a non-divide opcode leaves the block IDLE with BUSY=0.
- RESULT holds its value until the next completion.

## Timing
- Reset (asynchronous, immediate): state=IDLE, BUSY=0, DONE=0, RESULT=0, internal registers 0. Reset mid-operation abandons the operation with no DONE.
- Normal latency, with the accept cycle as cycle 0:
  - Cycles 1–32: RUN.
  - Cycle 33: SIGN.
  - Cycle 34: DONE=1 and RESULT valid.
  - BUSY is high in cycles 0–33.
- Fast-path latency: DONE=1 in cycle 1; BUSY is high in cycle 0 only.
- Back-to-back divides: the next accept is possible at cycle 35 (IDLE), one cycle after DONE.
- START held high during RUN/SIGN has no effect; operand changes after the accept have no effect.

## Structure
- Package div_pkg holds:
  - localparams ALU_DIV=5'b01100, ALU_DIVU=5'b01101, ALU_REM=5'b01110, ALU_REMU=5'b01111;
  - the state encoding (IDLE=2'd0, RUN=2'd1, SIGN=2'd2, DONE=2'd3);
  - DIV_ITERS=32.
- Sub-module div_step: combinational single restoring iteration (in: rem, quo, divisor; out: next rem, next quo). It is instantiated once, with the sequencer owning all state.

## Test plan
- DIV 100/7 accepted at cycle 0: BUSY high cycles 0–33, DONE at cycle 34 with RESULT=14. REM on the same operands gives RESULT=2.
- Signs: DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 gives 0x7FFFFFFC; REMU on the same operands gives 1.
- Divide by zero: DIV 5/0 gives DONE at cycle 1 with RESULT=0xFFFFFFFF; REMU 5/0 gives RESULT=5.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives DONE at cycle 1 with RESULT=0x80000000; REM on the same operands gives 0.
- FLUSH at cycle 10 of a DIV: IDLE at cycle 11, BUSY=0, no DONE, RESULT unchanged. A new START at cycle 11 is accepted and completes at cycle 45.
- RESET_N low at cycle 20 mid-operation: BUSY, DONE and RESULT go to 0 immediately. START with ALU_OPCODE=5'b00000 (ADD): BUSY stays 0 and DONE never pulses.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the RV32M divide sequencer: ALU opcodes,
// FSM state encoding and iteration count.
package div_pkg;

    localparam logic [4:0] ALU_DIV  = 5'b01100;
    localparam logic [4:0] ALU_DIVU = 5'b01101;
    localparam logic [4:0] ALU_REM  = 5'b01110;
    localparam logic [4:0] ALU_REMU = 5'b01111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int DIV_ITERS = 32;

    // The four divide opcodes share the prefix 3'b011.
    function automatic logic is_div_op(input logic [4:0] op);
        return (op[4:2] == 3'b011);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, then
// subtract the divisor from the partial remainder when it fits.
module div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [33:0] shifted;
    logic [33:0] diff;
    logic        fits;

    // Compare/subtract is done one bit wider than rem so no borrow is lost.
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        diff    = shifted - {2'b00, divisor_i};
        fits    = (shifted >= {2'b00, divisor_i});
        rem_o   = fits ? 33'(diff) : 33'(shifted);
        quo_o   = {quo_i[30:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit beside the EX-stage ALU.
// Handshake: an operation is accepted in IDLE when START=1, FLUSH=0 and
// ALU_OPCODE is a divide; BUSY is raised combinationally in that same
// cycle and stays high until the DONE cycle, in which BUSY=0, DONE=1 and
// RESULT is valid so EX captures it on the following edge.
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [4:0]      ALU_OPCODE,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [1:0]      STATE_DBG
);

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    logic [1:0]  state_q, state_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] divisor_q, divisor_d;
    logic [5:0]  count_q, count_d;
    logic        op_is_rem_q, op_is_rem_d;
    logic        op_is_signed_q, op_is_signed_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic [31:0] result_q, result_d;

    logic        accept;
    logic        in_signed;
    logic        in_rem;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_by_zero;
    logic        overflow;
    logic [32:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Decode the incoming request and prepare magnitudes / special cases.
    always_comb begin
        accept      = (state_q == ST_IDLE) & START & ~FLUSH & is_div_op(ALU_OPCODE);
        in_signed   = ~ALU_OPCODE[0];
        in_rem      = ALU_OPCODE[1];
        abs_a       = (in_signed & OPERAND1[31]) ? (32'd0 - OPERAND1) : OPERAND1;
        abs_b       = (in_signed & OPERAND2[31]) ? (32'd0 - OPERAND2) : OPERAND2;
        div_by_zero = (OPERAND2 == 32'd0);
        overflow    = in_signed & (OPERAND1 == 32'h8000_0000) & (OPERAND2 == 32'hFFFF_FFFF);
        quo_fin     = neg_q_q ? (32'd0 - quo_q) : quo_q;
        rem_fin     = neg_r_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        divisor_d      = divisor_q;
        count_d        = count_q;
        op_is_rem_d    = op_is_rem_q;
        op_is_signed_d = op_is_signed_q;
        neg_q_d        = neg_q_q;
        neg_r_d        = neg_r_q;
        result_d       = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_is_rem_d    = in_rem;
                    op_is_signed_d = in_signed;
                    neg_q_d        = in_signed & (OPERAND1[31] ^ OPERAND2[31]);
                    neg_r_d        = in_signed & OPERAND1[31];
                    quo_d          = abs_a;
                    divisor_d      = abs_b;
                    rem_d          = 33'd0;
                    count_d        = 6'd0;
                    if (div_by_zero) begin
                        result_d = in_rem ? OPERAND1 : 32'hFFFF_FFFF;
                        state_d  = ST_DONE;
                    end else if (overflow) begin
                        result_d = in_rem ? 32'd0 : 32'h8000_0000;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q + 6'd1;
                    if (count_q == LAST_ITER) begin
                        state_d = ST_SIGN;
                    end
                end
            end
            ST_SIGN: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = op_is_rem_q ? rem_fin : quo_fin;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            rem_q          <= 33'd0;
            quo_q          <= 32'd0;
            divisor_q      <= 32'd0;
            count_q        <= 6'd0;
            op_is_rem_q    <= 1'b0;
            op_is_signed_q <= 1'b0;
            neg_q_q        <= 1'b0;
            neg_r_q        <= 1'b0;
            result_q       <= 32'd0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            divisor_q      <= divisor_d;
            count_q        <= count_d;
            op_is_rem_q    <= op_is_rem_d;
            op_is_signed_q <= op_is_signed_d;
            neg_q_q        <= neg_q_d;
            neg_r_q        <= neg_r_d;
            result_q       <= result_d;
        end
    end

    // Outputs: BUSY covers the accept cycle through SIGN; DONE is the DONE state.
    always_comb begin
        BUSY      = (state_q == ST_RUN) | (state_q == ST_SIGN) | accept;
        DONE      = (state_q == ST_DONE);
        RESULT    = result_q;
        STATE_DBG = state_q;
    end

endmodule
